// File: rtl/alu_sequencer.sv
// Single-operation ALU sequencer: accepts one opcode/operand pair, drives a registered
// external ALU for 1 or MULDIV_CYCLES cycles, then holds the captured result until taken.
module alu_sequencer #(
  parameter int REG_SIZE      = 32,
  parameter int MULDIV_CYCLES = 4
) (
  input  logic                  clk,
  input  logic                  clr,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [3:0]            in_op,
  input  logic [REG_SIZE-1:0]   in_a,
  input  logic [REG_SIZE-1:0]   in_b,
  output logic [3:0]            alu_ctrl,
  output logic [REG_SIZE-1:0]   alu_a,
  output logic [REG_SIZE-1:0]   alu_b,
  input  logic [2*REG_SIZE-1:0] alu_result,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [REG_SIZE-1:0]   z_hi,
  output logic [REG_SIZE-1:0]   z_lo,
  output logic                  out_err,
  output logic [15:0]           op_count
);

  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

  localparam logic [5:0] MULDIV_LOAD = 6'(MULDIV_CYCLES - 1);

  state_t      state;
  state_t      state_d;
  logic [5:0]  cnt;
  logic [15:0] op_count_q;
  logic        accept;
  logic        legal;

  // Counter preload is latency minus one; only mul and div take more than one cycle.
  function automatic logic [5:0] load_value(input logic [3:0] op);
    if (op == 4'b1000 || op == 4'b1001) return MULDIV_LOAD;
    return 6'd0;
  endfunction

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign accept    = in_valid && in_ready;
  assign legal     = (in_op < 4'b1100);
  assign op_count  = op_count_q;

  always_comb begin
    state_d = state;
    case (state)
      IDLE:    if (accept) state_d = legal ? EXEC : DONE;
      EXEC:    if (cnt == 6'd0) state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state      <= IDLE;
      cnt        <= 6'd0;
      alu_ctrl   <= 4'd0;
      alu_a      <= '0;
      alu_b      <= '0;
      z_hi       <= '0;
      z_lo       <= '0;
      out_err    <= 1'b0;
      op_count_q <= 16'd0;
    end else begin
      state <= state_d;
      // ALU drive registers change only here, so they stay stable through EXEC and DONE.
      if (accept) begin
        alu_ctrl <= in_op;
        alu_a    <= in_a;
        alu_b    <= in_b;
        if (legal) begin
          cnt <= load_value(in_op);
        end else begin
          z_hi    <= '0;
          z_lo    <= '0;
          out_err <= 1'b1;
        end
      end
      if (state == EXEC) begin
        if (cnt == 6'd0) begin
          {z_hi, z_lo} <= alu_result;
          out_err      <= 1'b0;
        end else begin
          cnt <= cnt - 6'd1;
        end
      end
      if (state == DONE && out_ready) op_count_q <= sat_inc(op_count_q);
    end
  end

endmodule

// File: doc/alu_sequencer.md
ALU_SEQUENCER -- requirements
Module: alu_sequencer

Interface
REQ-001 Parameter REG_SIZE, default 32, operand width; results are 2*REG_SIZE bits.
REQ-002 Parameter MULDIV_CYCLES, default 4, range 1-64, number of EXEC cycles for mul (1000) and div (1001).
REQ-003 Clocking SHALL be: one clock, clk; reset clr is synchronous and active-high.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 clr  input  1  synchronous active-high reset.
REQ-006 in_valid  input  1  requester presents an operation.
REQ-007 in_ready  output  1  sequencer can accept an operation.
REQ-008 in_op  input  4  ALU opcode (0000 and ... 1011 not; 1100-1111 illegal).
REQ-009 in_a, in_b  input  REG_SIZE  operands.
REQ-010 alu_ctrl  output  4  ALU control, registered.
REQ-011 alu_a, alu_b  output  REG_SIZE  ALU operands, registered.
REQ-012 alu_result  input  2*REG_SIZE  combinational ALU result.
REQ-013 out_valid  output  1  result available.
REQ-014 out_ready  input  1  consumer takes result.
REQ-015 z_hi, z_lo  output  REG_SIZE  upper/lower halves of captured result.
REQ-016 out_err  output  1  result belongs to an illegal opcode.
REQ-017 op_count  output  16  completed-operation counter.

Function
REQ-018 FSM states SHALL be IDLE, EXEC, DONE; in_ready SHALL equal (state==IDLE).
REQ-019 IDLE: on in_valid&in_ready, latch in_op/in_a/in_b into alu_ctrl/alu_a/alu_b; legal opcode -> EXEC with cycle counter loaded to L-1; illegal opcode -> DONE with out_err=1, z_hi=z_lo=0.
REQ-020 L SHALL be 1 for opcodes 0000-0111 and 1010-1011, and MULDIV_CYCLES for 1000-1001.
REQ-021 alu_ctrl/alu_a/alu_b SHALL change only on accept or reset; they stay stable through EXEC and DONE.
REQ-022 EXEC: counter decrements each cycle; on the cycle counter==0, capture alu_result into {z_hi,z_lo}, clear out_err, go DONE.
REQ-023 Latency: accept at edge N -> out_valid high from edge N+L+1 (simple op: N+2; mul/div default: N+5); illegal: N+1.
REQ-024 DONE: out_valid=1, z_hi/z_lo/out_err held; on out_ready go IDLE; out_ready while not DONE SHALL be ignored.
REQ-025 No back-to-back accept: after DONE handshake, IDLE holds for at least one cycle before the next accept.
REQ-026 in_valid while not IDLE SHALL be ignored; in_op/in_a/in_b changes SHALL not affect an operation in flight.
REQ-027 op_count SHALL increment by 1 on each DONE->IDLE handshake (including illegal ops) and saturate at 16'hFFFF.
REQ-028 Result captured verbatim: no sign-extension or truncation by the sequencer; z_hi = alu_result[2*REG_SIZE-1:REG_SIZE].

Reset
REQ-029 clr SHALL override all other inputs on the same edge: state IDLE, counter 0, alu_ctrl 0, alu_a/alu_b 0, z_hi/z_lo 0, out_err 0, out_valid 0, op_count 0.
REQ-030 clr during EXEC or DONE SHALL abort the operation with no result and no op_count increment; in_ready=1 on the cycle after clr deasserts.

Verification
REQ-031 Add: accept in_op=0010, in_a=5, in_b=7 at edge N, out_ready=1 -> out_valid at N+2, z_lo=12, z_hi=0, out_err=0, op_count=1.
REQ-032 Mul: in_op=1000, in_a=0xFFFFFFFF, in_b=2, stub ALU returns 64'h1_FFFFFFFE -> out_valid at N+5, z_hi=1, z_lo=0xFFFFFFFE; in_ready low N+1..N+5.
REQ-033 Illegal: in_op=1101 -> out_valid at N+1, out_err=1, z_hi=z_lo=0, alu result ignored.
REQ-034 Backpressure: out_ready=0 for 10 cycles in DONE -> out_valid, z held constant, in_valid pulses ignored; out_ready=1 -> IDLE next cycle.
REQ-035 Reset mid-op: clr at N+2 of a div -> next cycle out_valid=0, all outputs 0, op_count unchanged at 0.
REQ-036 Saturation: force 65536 completed ops -> op_count remains 0xFFFF.
